instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Receiving end of the fetch-to-decode handshake.
- Accepts variable-length instructions (1–15 bytes) from fetch through a valid/ready handshake and buffers them in a small circular queue.
- Presents them first-word-fall-through to the decode core, which may stall.
- Supports a single-cycle flush for PC redirects. Sits between fetch and decode.

Parameters:
- DEPTH, 4, number of instruction entries; power of two, minimum 2.
- INSTR_WIDTH, `MAX_INSTR_WIDTH (120), instruction bits; byte 0 is in bits [7:0].
- LEN_WIDTH, 4, width of the instruction length field in bytes.
- CNT_WIDTH, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 resets on the next rising edge of clk.
- i_flush  in  1  discard all buffered entries (PC redirect).
- i_fetch_valid  in  1  fetch presents an instruction; connects to fetch o_res_valid.
- i_fetch_instr  in  INSTR_WIDTH  instruction bytes from fetch.
- i_fetch_instr_len  in  LEN_WIDTH  instruction length in bytes.
- o_fetch_ready  out  1  queue can accept this cycle; connects to fetch i_dec_ready.
- o_valid  out  1  head entry valid toward decode.
- o_instr  out  INSTR_WIDTH  head instruction.
- o_instr_len  out  LEN_WIDTH  head instruction length.
- i_dec_ready  in  1  decode consumes the head when o_valid is also high.
- o_count  out  CNT_WIDTH  current occupancy.

Behaviour:
- State: storage array, wr_ptr and rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset (reset==0 at a clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - Storage contents are don't-care.
  - While reset==0, o_fetch_ready=0, o_valid=0, o_instr=0, o_instr_len=0 and o_count=0.
- Push = i_fetch_valid && o_fetch_ready && (i_fetch_instr_len != 0).
  - Length 0 is illegal; the instruction is handshaken (accepted) and dropped, not stored.
- Pop = o_valid && i_dec_ready.
- o_fetch_ready = reset && !i_flush && (count != DEPTH).
  - Combinational from registers and i_flush only.
  - No path from i_dec_ready, so a full queue does not accept a push in the same cycle as a pop.
- o_valid = reset && !i_flush && (count != 0).
- o_instr / o_instr_len = head entry when count != 0, otherwise all zeros.
- Write masking: on push, byte k is stored only for k < len. Bits [INSTR_WIDTH-1:8*len] are stored as 0.
- Latency: an instruction pushed at edge N appears on o_valid after edge N. There is no same-cycle bypass when empty.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (only possible when 0 < count < DEPTH): count unchanged, both pointers advance.
- Stall: while o_valid && !i_dec_ready, o_instr and o_instr_len hold their values.
- Ordering: strict FIFO; pointers wrap from DEPTH-1 to 0.
- Flush priority: i_flush overrides push and pop in the same cycle.
  - Next state is count=0, rd_ptr=wr_ptr=0.
  - Nothing is accepted or consumed in the flush cycle (both ready and valid are low).
- Reset has priority over flush.
- Reset mid-operation discards all entries; there is no partial draining.
- Assertion (sim only): count never exceeds DEPTH and never underflows.

Decomposition:
- header.v holds shared constants:
  - `MAX_INSTR_WIDTH
  - new `INSTR_LEN_WIDTH (4)
  - new `INSTR_QUEUE_DEPTH (4)
- Fetch and decode use the same length width.
- One sub-module is natural: instr_queue_ram.
  - DEPTH x (INSTR_WIDTH+LEN_WIDTH) storage.
  - Synchronous write, asynchronous read.
  - Masking and pointer/count control stay in instr_queue.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles with i_fetch_valid=1 -> o_fetch_ready=0, o_valid=0, o_count=0. After release: o_fetch_ready=1, o_valid=0.
- Single push:
  - Stimulus: i_fetch_instr=120'h…AABB_CCDD, len=2, i_dec_ready=0.
  - Next cycle: o_valid=1, o_instr=120'h0…00CCDD, o_instr_len=2, o_count=1.
  - Values hold while stalled for 5 cycles.
- Fill and backpressure:
  - Stimulus: push lengths 1, 2, 3, 4 with i_dec_ready=0.
  - After the 4th push: o_count=4, o_fetch_ready=0; a 5th instruction held valid is not taken.
  - Raise i_dec_ready: lengths pop in order 1, 2, 3, 4; the 5th is accepted one cycle after the first pop.
- Wrap-around streaming: continuous push and pop with i_dec_ready=1 for 20 instructions with len = (i%15)+1 -> output sequence matches input exactly, o_count stays at 1, pointers wrap at least 4 times.
- Flush:
  - Stimulus: with 3 entries queued, assert i_flush concurrently with i_fetch_valid=1 and i_dec_ready=1.
  - During the flush cycle: o_valid=0, o_fetch_ready=0.
  - Next cycle: o_count=0, and the instruction presented during the flush is not stored.
- Illegal length: push len=0 -> o_fetch_ready handshake completes but o_count stays 0 and o_valid stays 0.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared sizing constants for the fetch-to-decode instruction queue.
// Fetch and decode use the same instruction and length widths.
package instr_queue_pkg;
  localparam int MAX_INSTR_WIDTH   = 120;
  localparam int INSTR_LEN_WIDTH   = 4;
  localparam int INSTR_QUEUE_DEPTH = 4;
endpackage

// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle.
// The queue takes the slave side; fetch, decode and the redirect source take the master side.
interface instr_queue_if
  import instr_queue_pkg::*;
#(
  parameter int INSTR_WIDTH = MAX_INSTR_WIDTH,
  parameter int LEN_WIDTH   = INSTR_LEN_WIDTH,
  parameter int CNT_WIDTH   = $clog2(INSTR_QUEUE_DEPTH) + 1
);
  logic                   i_flush;
  logic                   i_fetch_valid;
  logic [INSTR_WIDTH-1:0] i_fetch_instr;
  logic [LEN_WIDTH-1:0]   i_fetch_instr_len;
  logic                   o_fetch_ready;
  logic                   o_valid;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [LEN_WIDTH-1:0]   o_instr_len;
  logic                   i_dec_ready;
  logic [CNT_WIDTH-1:0]   o_count;

  modport slave (
    input  i_flush, i_fetch_valid, i_fetch_instr, i_fetch_instr_len, i_dec_ready,
    output o_fetch_ready, o_valid, o_instr, o_instr_len, o_count
  );

  modport master (
    output i_flush, i_fetch_valid, i_fetch_instr, i_fetch_instr_len, i_dec_ready,
    input  o_fetch_ready, o_valid, o_instr, o_instr_len, o_count
  );
endinterface

// File: rtl/instr_queue_ram.sv
// Entry storage for the instruction queue: synchronous write, asynchronous read.
// Contents are never reset; validity is tracked by the queue's occupancy count.
module instr_queue_ram
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = INSTR_QUEUE_DEPTH,
  parameter int WIDTH = MAX_INSTR_WIDTH + INSTR_LEN_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode, first-word-fall-through toward decode.
// Ready never depends on i_dec_ready, so a full queue cannot take a push in a popping cycle.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH       = INSTR_QUEUE_DEPTH,
  parameter int INSTR_WIDTH = MAX_INSTR_WIDTH,
  parameter int LEN_WIDTH   = INSTR_LEN_WIDTH,
  parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
  input logic         clk,
  input logic         reset,
  instr_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = INSTR_WIDTH + LEN_WIDTH;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 fetch_ready, head_valid, push, pop;
  logic [ENT_W-1:0]     wr_data, rd_data;

  // Bytes at or above the instruction length are stored as zero.
  function automatic logic [INSTR_WIDTH-1:0] mask_bytes(input logic [INSTR_WIDTH-1:0] data,
                                                        input logic [LEN_WIDTH-1:0]   len);
    logic [INSTR_WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < INSTR_WIDTH / 8; k++) begin
      if (k < int'(len)) res[8*k +: 8] = data[8*k +: 8];
    end
    return res;
  endfunction

  always_comb begin
    fetch_ready = reset && !q.i_flush && (count_q != FULL);
    head_valid  = reset && !q.i_flush && (count_q != '0);
    // A zero-length instruction completes the handshake but is dropped.
    push        = q.i_fetch_valid && fetch_ready && (q.i_fetch_instr_len != '0);
    pop         = head_valid && q.i_dec_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (q.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_data = {q.i_fetch_instr_len, mask_bytes(q.i_fetch_instr, q.i_fetch_instr_len)};

  instr_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign q.o_fetch_ready = fetch_ready;
  assign q.o_valid       = head_valid;
  assign {q.o_instr_len, q.o_instr} = (reset && (count_q != '0)) ? rd_data : '0;
  assign q.o_count       = reset ? count_q : '0;

  always @(posedge clk) begin
    if (reset) begin
      assert (count_q <= FULL);
      assert (!(pop && (count_q == '0)));
      assert (!(push && !pop && (count_q == FULL)));
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: reset/stall sequences, a table of fill/flush/illegal-length vectors,
// streaming wrap-around and randomized traffic, all compared against a queue-based model.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = INSTR_QUEUE_DEPTH;
  localparam int IW    = MAX_INSTR_WIDTH;
  localparam int LW    = INSTR_LEN_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_queue_if #(.INSTR_WIDTH(IW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) ifc ();

  instr_queue #(
    .DEPTH       (DEPTH),
    .INSTR_WIDTH (IW),
    .LEN_WIDTH   (LW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (ifc)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [LW-1:0] len;
  } ent_t;

  typedef struct {
    logic          fl;
    logic          fv;
    logic [IW-1:0] ins;
    logic [LW-1:0] ln;
    logic          dr;
    logic          e_rdy;
    logic          e_vld;
    logic [CW-1:0] e_cnt;
    logic [LW-1:0] e_len;
    logic [IW-1:0] e_ins;
  } vec_t;

  ent_t mq[$];
  vec_t vecs[18];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic          cur_rst, cur_fl, cur_fv, cur_dr;
  logic [IW-1:0] cur_ins;
  logic [LW-1:0] cur_len;
  logic          exp_rdy, exp_vld;

  // Model: keep the low len bytes, computed as an arithmetic mask.
  function automatic logic [IW-1:0] keep_bytes(input logic [IW-1:0] ins, input logic [LW-1:0] len);
    logic [127:0] m;
    m = (128'd1 << (8 * len)) - 128'd1;
    return ins & m[IW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic fv,
                       input logic [IW-1:0] ins, input logic [LW-1:0] len, input logic dr);
    cur_rst = rst; cur_fl = fl; cur_fv = fv; cur_ins = ins; cur_len = len; cur_dr = dr;
    reset                 = rst;
    ifc.i_flush           = fl;
    ifc.i_fetch_valid     = fv;
    ifc.i_fetch_instr     = ins;
    ifc.i_fetch_instr_len = len;
    ifc.i_dec_ready       = dr;
  endtask

  task automatic model_check();
    @(negedge clk);
    exp_rdy = cur_rst && !cur_fl && (mq.size() != DEPTH);
    exp_vld = cur_rst && !cur_fl && (mq.size() != 0);
    chk("m_ready", 128'(ifc.o_fetch_ready), 128'(exp_rdy));
    chk("m_valid", 128'(ifc.o_valid), 128'(exp_vld));
    chk("m_count", 128'(ifc.o_count), 128'(cur_rst ? mq.size() : 0));
    if (cur_rst && mq.size() != 0) begin
      chk("m_instr", 128'(ifc.o_instr), 128'(mq[0].instr));
      chk("m_len", 128'(ifc.o_instr_len), 128'(mq[0].len));
    end else begin
      chk("m_instr", 128'(ifc.o_instr), 128'd0);
      chk("m_len", 128'(ifc.o_instr_len), 128'd0);
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (!cur_rst || cur_fl) begin
      mq.delete();
    end else begin
      if (exp_vld && cur_dr) void'(mq.pop_front());
      if (exp_rdy && cur_fv && cur_len != 0)
        mq.push_back('{instr: keep_bytes(cur_ins, cur_len), len: cur_len});
    end
    #1;
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic fv,
                       input logic [IW-1:0] ins, input logic [LW-1:0] len, input logic dr);
    drive(rst, fl, fv, ins, len, dr);
    model_check();
    commit();
  endtask

  function automatic logic [IW-1:0] rnd_instr();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[IW-1:0];
  endfunction

  initial begin
    // fl, fv, ins, ln, dr, e_rdy, e_vld, e_cnt, e_len, e_ins
    vecs[0]  = '{1'b0, 1'b1, {15{8'hA1}}, 4'd1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 120'h0};
    vecs[1]  = '{1'b0, 1'b1, {15{8'hB2}}, 4'd2, 1'b0, 1'b1, 1'b1, 3'd1, 4'd1, 120'hA1};
    vecs[2]  = '{1'b0, 1'b1, {15{8'hC3}}, 4'd3, 1'b0, 1'b1, 1'b1, 3'd2, 4'd1, 120'hA1};
    vecs[3]  = '{1'b0, 1'b1, {15{8'hD4}}, 4'd4, 1'b0, 1'b1, 1'b1, 3'd3, 4'd1, 120'hA1};
    vecs[4]  = '{1'b0, 1'b1, {15{8'hE5}}, 4'd5, 1'b0, 1'b0, 1'b1, 3'd4, 4'd1, 120'hA1};
    vecs[5]  = '{1'b0, 1'b1, {15{8'hE5}}, 4'd5, 1'b1, 1'b0, 1'b1, 3'd4, 4'd1, 120'hA1};
    vecs[6]  = '{1'b0, 1'b1, {15{8'hE5}}, 4'd5, 1'b1, 1'b1, 1'b1, 3'd3, 4'd2, 120'hB2B2};
    vecs[7]  = '{1'b0, 1'b0, 120'h0,      4'd0, 1'b1, 1'b1, 1'b1, 3'd3, 4'd3, 120'hC3C3C3};
    vecs[8]  = '{1'b0, 1'b0, 120'h0,      4'd0, 1'b1, 1'b1, 1'b1, 3'd2, 4'd4, 120'hD4D4D4D4};
    vecs[9]  = '{1'b0, 1'b0, 120'h0,      4'd0, 1'b1, 1'b1, 1'b1, 3'd1, 4'd5, 120'hE5E5E5E5E5};
    vecs[10] = '{1'b0, 1'b0, 120'h0,      4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 120'h0};
    vecs[11] = '{1'b0, 1'b1, {15{8'hF6}}, 4'd6, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 120'h0};
    vecs[12] = '{1'b0, 1'b1, {15{8'h97}}, 4'd7, 1'b0, 1'b1, 1'b1, 3'd1, 4'd6, 120'hF6F6F6F6F6F6};
    vecs[13] = '{1'b0, 1'b1, {15{8'h88}}, 4'd8, 1'b0, 1'b1, 1'b1, 3'd2, 4'd6, 120'hF6F6F6F6F6F6};
    vecs[14] = '{1'b1, 1'b1, {15{8'h79}}, 4'd9, 1'b1, 1'b0, 1'b0, 3'd3, 4'd6, 120'hF6F6F6F6F6F6};
    vecs[15] = '{1'b0, 1'b0, 120'h0,      4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 120'h0};
    vecs[16] = '{1'b0, 1'b1, {15{8'h6A}}, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 120'h0};
    vecs[17] = '{1'b0, 1'b0, 120'h0,      4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 120'h0};

    drive(1'b0, 1'b0, 1'b1, {15{8'h5A}}, 4'd3, 1'b0);

    // Reset held low with fetch presenting: nothing accepted, outputs quiet.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, {15{8'h5A}}, 4'd3, 1'b0);
      model_check();
      chk("rst_ready", 128'(ifc.o_fetch_ready), 128'd0);
      chk("rst_valid", 128'(ifc.o_valid), 128'd0);
      chk("rst_count", 128'(ifc.o_count), 128'd0);
      commit();
    end
    drive(1'b1, 1'b0, 1'b0, 120'h0, 4'd0, 1'b0);
    model_check();
    chk("idle_ready", 128'(ifc.o_fetch_ready), 128'd1);
    chk("idle_valid", 128'(ifc.o_valid), 128'd0);
    commit();

    // Single push of a 2-byte instruction, then a 6-cycle decode stall.
    cycle(1'b1, 1'b0, 1'b1, 120'h0102030405060708090A0BAABBCCDD, 4'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 120'h0, 4'd0, 1'b0);
      model_check();
      chk("sp_valid", 128'(ifc.o_valid), 128'd1);
      chk("sp_instr", 128'(ifc.o_instr), 128'hCCDD);
      chk("sp_len", 128'(ifc.o_instr_len), 128'd2);
      chk("sp_count", 128'(ifc.o_count), 128'd1);
      commit();
    end
    cycle(1'b1, 1'b0, 1'b0, 120'h0, 4'd0, 1'b1);

    // Fill/backpressure, flush with concurrent traffic, illegal length.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vecs[i].fl, vecs[i].fv, vecs[i].ins, vecs[i].ln, vecs[i].dr);
      model_check();
      chk($sformatf("v%0d_ready", i), 128'(ifc.o_fetch_ready), 128'(vecs[i].e_rdy));
      chk($sformatf("v%0d_valid", i), 128'(ifc.o_valid), 128'(vecs[i].e_vld));
      chk($sformatf("v%0d_count", i), 128'(ifc.o_count), 128'(vecs[i].e_cnt));
      chk($sformatf("v%0d_len", i), 128'(ifc.o_instr_len), 128'(vecs[i].e_len));
      chk($sformatf("v%0d_instr", i), 128'(ifc.o_instr), 128'(vecs[i].e_ins));
      commit();
    end

    // Streaming push+pop: occupancy stays at one, pointers wrap five times.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, rnd_instr(), LW'((i % 15) + 1), 1'b1);
      model_check();
      chk("stream_count", 128'(ifc.o_count), (i == 0) ? 128'd0 : 128'd1);
      commit();
    end
    cycle(1'b1, 1'b0, 1'b0, 120'h0, 4'd0, 1'b1);

    // Reset in the middle of operation discards everything.
    cycle(1'b1, 1'b0, 1'b1, rnd_instr(), 4'd15, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, rnd_instr(), 4'd7, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, rnd_instr(), 4'd3, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 120'h0, 4'd0, 1'b0);
    model_check();
    chk("midrst_count", 128'(ifc.o_count), 128'd0);
    chk("midrst_valid", 128'(ifc.o_valid), 128'd0);
    commit();

    // Randomized traffic: low drain rate first, then high.
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 49) != 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7,
            rnd_instr(),
            LW'($urandom_range(0, 15)),
            $urandom_range(0, 9) < ((k < 300) ? 3 : 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
